axi_mem_responder: RTL
======================

Name: axi_mem_responder

Overview:
AXI-subset slave that is the far end of the core's memory port. It accepts the core's AW/W/B and AR/R bursts and answers them from an internal word-addressed memory array. It serves as the memory model under mips_core in simulation and FPGA bring-up. The read and write channels run as independent state machines, so a read burst and a write burst may be in flight at the same time.

Parameters:
ADDR_WIDTH, 26, byte-address width (matches `ADDR_WIDTH)
DATA_WIDTH, 32, beat width (matches `DATA_WIDTH)
MEM_WORDS_LOG2, 14, log2 of array depth in words
READ_LATENCY, 2, cycles from AR handshake to first R beat; legal range 1..15

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
AWREADY  out  1  write address accepted
AWVALID  in  1  write address valid
AWID  in  4  write transaction id
AWLEN  in  4  write beats minus 1
AWADDR  in  ADDR_WIDTH  write start byte address
WREADY  out  1  write data accepted
WVALID  in  1  write data valid
WLAST  in  1  last write beat marker
WID  in  4  write data id
WDATA  in  DATA_WIDTH  write beat data
BREADY  in  1  master ready for response
BVALID  out  1  write response valid
BID  out  4  response id (= accepted AWID)
ARREADY  out  1  read address accepted
ARVALID  in  1  read address valid
ARID  in  4  read transaction id
ARLEN  in  4  read beats minus 1
ARADDR  in  ADDR_WIDTH  read start byte address
RREADY  in  1  master ready for read beat
RVALID  out  1  read beat valid
RLAST  out  1  last read beat
RID  out  4  read id (= accepted ARID)
RDATA  out  DATA_WIDTH  read beat data
protocol_err  out  1  sticky protocol violation flag

Behaviour:
- Clocking and reset:
  - Single clock, synchronous active-high reset.
  - Handshake on a channel = VALID && READY sampled at posedge clk.
- Reset values:
  - AWREADY=1, ARREADY=1.
  - WREADY=0, BVALID=0, RVALID=0, RLAST=0.
  - BID=0, RID=0, RDATA=0, protocol_err=0.
  - Array contents are not cleared.
  - Reset mid-burst aborts the burst: both FSMs go to IDLE and all VALIDs are low the cycle after rst.
- Addressing:
  - Word index = ADDR[MEM_WORDS_LOG2+1:2]; ADDR[1:0] and upper bits are ignored.
  - Beat k uses index (start+k) mod 2^MEM_WORDS_LOG2, so index wrap-around at the top is legal.
  - Burst length = LEN+1 (1..16 beats), incrementing, full-word writes only.
- Write FSM (states W_IDLE, W_DATA, W_RESP):
  - W_IDLE: AWREADY=1. On AW handshake, latch AWID, index and LEN, clear the beat counter, go to W_DATA. AWREADY drops the next cycle.
  - W_DATA: WREADY=1. Each W handshake writes WDATA to the array and increments the counter. W beats presented before the AW handshake wait (WREADY=0).
  - On the handshake of beat LEN, go to W_RESP; WREADY=0 the next cycle.
  - The burst length is set by AWLEN only. protocol_err is set if WLAST≠(counter==LEN) on any beat, or if WID≠latched AWID.
  - W_RESP: BVALID=1, BID=latched id, held stable until BREADY. On the B handshake, go to W_IDLE; AWREADY=1 the next cycle.
- Read FSM (states R_IDLE, R_WAIT, R_BURST):
  - R_IDLE: ARREADY=1. On AR handshake at cycle t, latch ARID, index and LEN, go to R_WAIT.
  - R_WAIT counts READ_LATENCY-1 cycles; RVALID first rises in cycle t+READ_LATENCY with beat 0 data.
  - R_BURST: RVALID=1; RID=latched id; RLAST=(counter==LEN). RDATA, RID and RLAST are held stable while RVALID && !RREADY.
  - On each R handshake, the next beat is presented the following cycle, so beats run back-to-back if RREADY is held. RVALID never deasserts mid-burst.
  - On the handshake of the RLAST beat, go to R_IDLE; RVALID=0 and ARREADY=1 the next cycle.
- Simultaneous read and write:
  - RDATA is registered when a beat is loaded.
  - If a W handshake writes the same index in the cycle that beat's RDATA is loaded, RDATA takes WDATA (write-first bypass).
  - Beats already presented are not updated.
- protocol_err is cleared only by rst.

Test Plan:
1. Write AWADDR=0x100, AWLEN=3, AWID=5, WDATA=0xA0..0xA3 with WLAST on beat 3 -> 4 WREADY handshakes, then BVALID with BID=5 one cycle after the last beat; protocol_err=0.
2. Read ARADDR=0x100, ARLEN=3, ARID=2 with RREADY=1 -> RVALID rises 2 cycles after AR; RDATA=0xA0,0xA1,0xA2,0xA3 on consecutive cycles; RLAST only on 0xA3; RID=2.
3. Repeat scenario 2 with RREADY toggling 1,0,0,1,… -> RDATA/RLAST held during stalls; same 4 values in order; ARREADY low until the cycle after the last handshake.
4. Write 2 beats at word index 2^14-1 (AWADDR=0xFFFC) -> second beat lands at index 0; read ARADDR=0x0, ARLEN=0 returns that second beat's data.
5. Write with AWLEN=1 but WLAST on beat 0 and WID≠AWID -> 2 beats still consumed, B still returned, protocol_err=1 and sticky until rst.
6. Assert rst during R_BURST after beat 1 with BVALID pending -> next cycle RVALID=0, BVALID=0, AWREADY=ARREADY=1; a subsequent read returns the previously written data unchanged.

Source files
------------

// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - AXI-subset memory slave with independent read and write burst engines
//
// Purpose: the far end of the core's memory port. It accepts AW/W/B write bursts and
// AR/R read bursts and answers them from an internal word-addressed array. Reads and
// writes run as separate state machines, so one burst of each kind can be in flight at once.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   AW*               write address channel (AWREADY out; AWVALID/AWID/AWLEN/AWADDR in)
//   W*                write data channel (WREADY out; WVALID/WLAST/WID/WDATA in)
//   B*                write response channel (BVALID/BID out; BREADY in)
//   AR*               read address channel (ARREADY out; ARVALID/ARID/ARLEN/ARADDR in)
//   R*                read data channel (RVALID/RLAST/RID/RDATA out; RREADY in)
//   protocol_err      sticky flag: WLAST placement or WID did not match the accepted AW
module axi_mem_responder #(
    parameter int ADDR_WIDTH     = 26,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_WORDS_LOG2 = 14,
    parameter int READ_LATENCY   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  AWREADY,
    input  logic                  AWVALID,
    input  logic [3:0]            AWID,
    input  logic [3:0]            AWLEN,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    output logic                  WREADY,
    input  logic                  WVALID,
    input  logic                  WLAST,
    input  logic [3:0]            WID,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  BREADY,
    output logic                  BVALID,
    output logic [3:0]            BID,
    output logic                  ARREADY,
    input  logic                  ARVALID,
    input  logic [3:0]            ARID,
    input  logic [3:0]            ARLEN,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  RREADY,
    output logic                  RVALID,
    output logic                  RLAST,
    output logic [3:0]            RID,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  protocol_err
);
    localparam int IDX_W = MEM_WORDS_LOG2;
    localparam int DEPTH = 1 << MEM_WORDS_LOG2;
    // R_WAIT holds READ_LATENCY-1 cycles; the counter runs from this value down to 0.
    localparam logic [3:0] WAIT_INIT = (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;

    w_state_t               w_state_q, w_state_d;
    logic [3:0]             aw_id_q, aw_id_d;
    logic [IDX_W-1:0]       w_idx_q, w_idx_d;
    logic [3:0]             w_len_q, w_len_d;
    logic [3:0]             w_cnt_q, w_cnt_d;
    logic                   perr_q, perr_d;

    r_state_t               r_state_q, r_state_d;
    logic [3:0]             ar_id_q, ar_id_d;
    logic [IDX_W-1:0]       r_idx_q, r_idx_d;
    logic [3:0]             r_len_q, r_len_d;
    logic [3:0]             r_cnt_q, r_cnt_d;
    logic [3:0]             r_wait_q, r_wait_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic                   mem_we;
    logic [IDX_W-1:0]       mem_waddr;
    logic                   load_en;
    logic [IDX_W-1:0]       load_idx;
    logic                   r_last;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^{AWADDR[ADDR_WIDTH-1:MEM_WORDS_LOG2+2], AWADDR[1:0],
                                ARADDR[ADDR_WIDTH-1:MEM_WORDS_LOG2+2], ARADDR[1:0]};

    // Index arithmetic is IDX_W bits wide, so bursts wrap past the top of the array.
    assign mem_waddr = w_idx_q + IDX_W'(w_cnt_q);
    // A beat accepted in the reset cycle is dropped along with the rest of the burst.
    assign mem_we    = (w_state_q == W_DATA) && WVALID && !rst;
    assign r_last    = (r_cnt_q == r_len_q);

    assign BID          = aw_id_q;
    assign RID          = ar_id_q;
    assign RDATA        = rdata_q;
    assign protocol_err = perr_q;

    always_comb begin
        w_state_d = w_state_q;
        aw_id_d   = aw_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        perr_d    = perr_q;
        AWREADY   = 1'b0;
        WREADY    = 1'b0;
        BVALID    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                AWREADY = 1'b1;
                if (AWVALID) begin
                    aw_id_d   = AWID;
                    w_idx_d   = AWADDR[MEM_WORDS_LOG2+1:2];
                    w_len_d   = AWLEN;
                    w_cnt_d   = 4'd0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                WREADY = 1'b1;
                if (WVALID) begin
                    w_cnt_d = w_cnt_q + 4'd1;
                    // AWLEN alone sets the burst length; a misplaced WLAST or a foreign WID is only flagged.
                    if ((WLAST != (w_cnt_q == w_len_q)) || (WID != aw_id_q)) begin
                        perr_d = 1'b1;
                    end
                    if (w_cnt_q == w_len_q) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        ar_id_d   = ar_id_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_wait_d  = r_wait_q;
        rdata_d   = rdata_q;
        ARREADY   = 1'b0;
        RVALID    = 1'b0;
        RLAST     = 1'b0;
        load_en   = 1'b0;
        load_idx  = r_idx_q + IDX_W'(r_cnt_q) + IDX_W'(1);
        case (r_state_q)
            R_IDLE: begin
                ARREADY = 1'b1;
                if (ARVALID) begin
                    ar_id_d = ARID;
                    r_idx_d = ARADDR[MEM_WORDS_LOG2+1:2];
                    r_len_d = ARLEN;
                    r_cnt_d = 4'd0;
                    if (READ_LATENCY == 1) begin
                        load_en   = 1'b1;
                        load_idx  = ARADDR[MEM_WORDS_LOG2+1:2];
                        r_state_d = R_BURST;
                    end else begin
                        r_wait_d  = WAIT_INIT;
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_wait_q == 4'd0) begin
                    load_en   = 1'b1;
                    load_idx  = r_idx_q;
                    r_state_d = R_BURST;
                end else begin
                    r_wait_d = r_wait_q - 4'd1;
                end
            end
            R_BURST: begin
                RVALID = 1'b1;
                RLAST  = r_last;
                if (RREADY) begin
                    if (r_last) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d = r_cnt_q + 4'd1;
                        load_en = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        // Write-first: a beat loaded while the same word is being written sees the new data.
        if (load_en) begin
            rdata_d = (mem_we && (mem_waddr == load_idx)) ? WDATA : mem_q[load_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            aw_id_q   <= '0;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            perr_q    <= 1'b0;
            r_state_q <= R_IDLE;
            ar_id_q   <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_wait_q  <= '0;
            rdata_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_id_q   <= aw_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            perr_q    <= perr_d;
            r_state_q <= r_state_d;
            ar_id_q   <= ar_id_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_wait_q  <= r_wait_d;
            rdata_q   <= rdata_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= WDATA;
        end
    end
endmodule
